mms_stream_collect: RTL and testbench
=====================================

// Module: mms_stream_collect
// PURPOSE
//  Upstream feeder for the 4-number max/min selector. Accepts a serial stream of
//  unsigned bytes over a valid/ready handshake, buffers them in groups of four,
//  reduces each group to its maximum or minimum, and presents the result on an
//  output valid/ready handshake. Turns a byte stream into one max/min per group.
// PARAMETERS
//  DATA_W   8   width of every data element and of the result (unsigned)
// PORTS
//  clk          in   1       rising-edge clock, sole clock domain
//  reset        in   1       synchronous, active-high reset
//  in_valid     in   1       in_data/in_select valid this cycle
//  in_ready     out  1       block can accept an element this cycle
//  in_data      in   DATA_W  stream element (unsigned)
//  in_select    in   1       0 = max, 1 = min; sampled with the 1st element of a group only
//  out_valid    out  1       out_result holds a completed group result
//  out_ready    in   1       downstream accepts result this cycle
//  out_result   out  DATA_W  max (select=0) or min (select=1) of the group
//  out_select   out  1       select value latched for the reported group
//  grp_cnt      out  2       elements held in the current partial group (0..3)
// BEHAVIOUR
//  - Reset (sync, clk edge with reset=1): state=COLLECT, grp_cnt=0, in_ready=1,
//    out_valid=0, out_result=0, out_select=0; any partial group discarded. Reset
//    overrides every other event in the same cycle, including a pending result.
//  - Transfer on each side only when valid && ready on the same rising edge.
//  - FSM, 2 states:
//    COLLECT: in_ready=1, out_valid=0. Each accepted element is written to slot
//      grp_cnt (slot0..slot3); grp_cnt increments. On slot0 write, in_select is
//      latched as the group select; in_select on slots 1..3 is ignored.
//      Accepting the 4th element (grp_cnt==3) -> OUT, grp_cnt wraps to 0.
//    OUT: in_ready=0, out_valid=1, out_result/out_select stable until accepted.
//      out_valid && out_ready -> COLLECT. Held indefinitely if out_ready=0.
//  - Latency: out_valid asserts the cycle after the 4th element is accepted;
//    out_result is registered (computed from slot0..3 with 4th element bypassed
//    into the compare at the accepting edge). Throughput: 1 group per 5 cycles min.
//  - Reduction: pairwise tree, m0=sel(slot0,slot1), m1=sel(slot2,slot3),
//    result=sel(m0,m1); sel picks larger for select=0, smaller for select=1.
//    Unsigned compare, DATA_W bits, no extension. Ties yield the equal value.
//  - in_valid with in_ready=0 is not an error; element is simply not taken.
//  - in_data/in_select X while in_valid=0 must not affect state.
// CONFIGURATION
//  MMS_RUNNING_EN defined: adds ports run_clr (in,1) and run_result (out,DATA_W).
//    run_result tracks max of all group results with out_select=0 since reset or
//    last run_clr; updated on each output transfer. reset or run_clr -> 0; run_clr
//    coincident with a transfer: cleared, then loaded with that transfer's result
//    if its out_select=0.
//  MMS_RUNNING_EN undefined: ports absent, no extra logic; core behaviour identical.
// TESTING
//  1. select=0, send 12,200,7,99, out_ready=1 -> out_valid 1 cycle after 4th accept,
//     out_result=200, out_select=0, in_ready low exactly 1 cycle.
//  2. select=1, send 12,200,7,99 -> out_result=7; in_select toggled on elements
//     2..4 has no effect.
//  3. Ties/extremes: select=0 {255,255,0,0} -> 255; select=1 {0,0,0,0} -> 0.
//  4. Backpressure: out_ready=0 for 10 cycles after result -> out_valid, out_result
//     stable, in_ready=0, further in_valid ignored; release -> next group collected.
//  5. Reset mid-group: accept 2 elements, pulse reset -> grp_cnt=0; next 4 elements
//     {1,2,3,4} select=0 -> out_result=4 (old elements not included).
//  6. MMS_RUNNING_EN: groups max 50 then 80 then 60 -> run_result 50,80,80;
//     run_clr -> 0.

Source files
------------

// File: rtl/mms_stream_collect.sv
// mms_stream_collect
//   Collects a valid/ready byte stream into groups of four and reduces each
//   group to its maximum (select=0) or minimum (select=1). The result is held
//   on a valid/ready output until downstream accepts it.
//   Optional feature macro: MMS_RUNNING_EN adds run_clr/run_result, a running
//   maximum over all max-mode group results.
module mms_stream_collect #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_select,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic              out_select,
  output logic [1:0]        grp_cnt
`ifdef MMS_RUNNING_EN
  ,
  input  logic              run_clr,
  output logic [DATA_W-1:0] run_result
`endif
);

  typedef enum logic {
    COLLECT = 1'b0,
    OUT     = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        grp_cnt_q, grp_cnt_d;
  logic [DATA_W-1:0] slot_q [3];
  logic [DATA_W-1:0] slot_d [3];
  logic              sel_q, sel_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_result_q, out_result_d;
  logic              out_select_q, out_select_d;

  logic              in_fire;
  logic              out_fire;
  logic [DATA_W-1:0] m0;
  logic [DATA_W-1:0] m1;

  // Larger of a/b when pick_min=0, smaller when pick_min=1; ties return the shared value.
  function automatic logic [DATA_W-1:0] pick(input logic [DATA_W-1:0] a,
                                             input logic [DATA_W-1:0] b,
                                             input logic              pick_min);
    if (pick_min) pick = (b < a) ? b : a;
    else          pick = (b > a) ? b : a;
  endfunction

  assign in_fire  = in_valid && in_ready_q;
  assign out_fire = out_valid_q && out_ready;

  // Reduction tree; the 4th element is never stored, it feeds m1 straight from in_data.
  always_comb begin
    m0 = pick(slot_q[0], slot_q[1], sel_q);
    m1 = pick(slot_q[2], in_data, sel_q);
  end

  // Next-state logic for the collect/output FSM and its registered outputs.
  always_comb begin
    state_d      = state_q;
    grp_cnt_d    = grp_cnt_q;
    slot_d       = slot_q;
    sel_d        = sel_q;
    in_ready_d   = in_ready_q;
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_select_d = out_select_q;
    unique case (state_q)
      COLLECT: begin
        if (in_fire) begin
          if (grp_cnt_q == 2'd0) sel_d = in_select;
          if (grp_cnt_q == 2'd3) begin
            out_result_d = pick(m0, m1, sel_q);
            out_select_d = sel_q;
            grp_cnt_d    = 2'd0;
            in_ready_d   = 1'b0;
            out_valid_d  = 1'b1;
            state_d      = OUT;
          end else begin
            for (int unsigned i = 0; i < 3; i++) begin
              if (grp_cnt_q == 2'(i)) slot_d[i] = in_data;
            end
            grp_cnt_d = 2'(grp_cnt_q + 2'd1);
          end
        end
      end
      OUT: begin
        if (out_fire) begin
          in_ready_d  = 1'b1;
          out_valid_d = 1'b0;
          state_d     = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  // State and output registers; reset wins over any pending transfer.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= COLLECT;
      grp_cnt_q    <= '0;
      for (int unsigned i = 0; i < 3; i++) slot_q[i] <= '0;
      sel_q        <= 1'b0;
      in_ready_q   <= 1'b1;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_select_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      grp_cnt_q    <= grp_cnt_d;
      slot_q       <= slot_d;
      sel_q        <= sel_d;
      in_ready_q   <= in_ready_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_select_q <= out_select_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_select = out_select_q;
  assign grp_cnt    = grp_cnt_q;

`ifdef MMS_RUNNING_EN
  logic [DATA_W-1:0] run_q, run_d;
  logic [DATA_W-1:0] run_base;

  // Clear first, then fold in a coincident max-mode result.
  always_comb begin
    run_base = run_clr ? '0 : run_q;
    run_d    = run_base;
    if (out_fire && !out_select_q && (out_result_q > run_base)) run_d = out_result_q;
  end

  // Running-maximum register.
  always_ff @(posedge clk) begin
    if (reset) run_q <= '0;
    else       run_q <= run_d;
  end

  assign run_result = run_q;
`endif

endmodule

// File: tb/tb_mms_stream_collect.sv
// tb_mms_stream_collect
//   Directed bench for mms_stream_collect. Expected group results come from a
//   linear-scan model and travel through a scoreboard queue to the output side.
//   Define MMS_RUNNING_EN for both files to cover the running-maximum ports.
module tb_mms_stream_collect;

  localparam int unsigned DATA_W = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_select;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_result;
  logic              out_select;
  logic [1:0]        grp_cnt;
`ifdef MMS_RUNNING_EN
  logic              run_clr;
  logic [DATA_W-1:0] run_result;
`endif

  always #5 clk = ~clk;

  mms_stream_collect #(.DATA_W(DATA_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_select  (in_select),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_select (out_select),
    .grp_cnt    (grp_cnt)
`ifdef MMS_RUNNING_EN
    ,
    .run_clr    (run_clr),
    .run_result (run_result)
`endif
  );

  typedef struct packed {
    logic [DATA_W-1:0] res;
    logic              sel;
  } exp_t;

  exp_t              sb[$];
  int                checks = 0;
  int                passed = 0;
  logic [DATA_W-1:0] m_slot [4];
  int unsigned       m_cnt = 0;
  logic              m_sel = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  function automatic logic [DATA_W-1:0] model_reduce(input logic mn);
    logic [DATA_W-1:0] r;
    r = m_slot[0];
    for (int i = 1; i < 4; i++) begin
      if (mn ? (m_slot[i] < r) : (m_slot[i] > r)) r = m_slot[i];
    end
    return r;
  endfunction

  // Offer one element and hold it until accepted (bounded).
  task automatic push(input logic [DATA_W-1:0] d, input logic s);
    int n;
    n         = 0;
    in_valid  = 1'b1;
    in_data   = d;
    in_select = s;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      chk("push_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    if (m_cnt == 0) m_sel = s;
    m_slot[m_cnt] = d;
    if (m_cnt == 3) begin
      sb.push_back('{res: model_reduce(m_sel), sel: m_sel});
      m_cnt = 0;
    end else begin
      m_cnt++;
    end
    in_valid  = 1'b0;
    in_data   = DATA_W'($urandom);
    in_select = 1'($urandom);
  endtask

  // Accept one result and compare it with the oldest scoreboard entry.
  task automatic take(input logic clr);
    int                n;
    logic [DATA_W-1:0] r;
    logic              s;
    exp_t              e;
    n         = 0;
    out_ready = 1'b1;
    while (!out_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!out_valid) begin
      chk("take_timeout", 32'(out_valid), 32'd1);
      out_ready = 1'b0;
      return;
    end
    r = out_result;
    s = out_select;
`ifdef MMS_RUNNING_EN
    run_clr = clr;
`endif
    @(posedge clk); #1;
    out_ready = 1'b0;
`ifdef MMS_RUNNING_EN
    run_clr = 1'b0;
`endif
    if (sb.size() == 0) begin
      chk("sb_nonempty", 32'(sb.size()), 32'd1);
      return;
    end
    e = sb.pop_front();
    chk("out_result", 32'(r), 32'(e.res));
    chk("out_select", 32'(s), 32'(e.sel));
    chk("out_valid_drop", 32'(out_valid), 32'd0);
    chk("in_ready_back", 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [DATA_W-1:0] held;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_select = 1'b0;
    out_ready = 1'b0;
`ifdef MMS_RUNNING_EN
    run_clr   = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_result", 32'(out_result), 32'd0);
    chk("rst_out_select", 32'(out_select), 32'd0);
    chk("rst_grp_cnt", 32'(grp_cnt), 32'd0);
`ifdef MMS_RUNNING_EN
    chk("rst_run_result", 32'(run_result), 32'd0);
`endif

    // Max of 12,200,7,99; result visible right after the 4th accept
    push(8'd12, 1'b0); push(8'd200, 1'b0);
    chk("grp_cnt_2", 32'(grp_cnt), 32'd2);
    push(8'd7, 1'b0); push(8'd99, 1'b0);
    chk("t1_out_valid", 32'(out_valid), 32'd1);
    chk("t1_in_ready_low", 32'(in_ready), 32'd0);
    chk("t1_grp_wrap", 32'(grp_cnt), 32'd0);
    take(1'b0);

    // Min; select toggled on later elements is ignored
    push(8'd12, 1'b1); push(8'd200, 1'b0); push(8'd7, 1'b0); push(8'd99, 1'b0);
    take(1'b0);
    push(8'd12, 1'b0); push(8'd200, 1'b1); push(8'd7, 1'b1); push(8'd99, 1'b1);
    take(1'b0);

    // Ties and extremes
    push(8'd255, 1'b0); push(8'd255, 1'b0); push(8'd0, 1'b0); push(8'd0, 1'b0);
    take(1'b0);
    push(8'd0, 1'b1); push(8'd0, 1'b1); push(8'd0, 1'b1); push(8'd0, 1'b1);
    take(1'b0);
    push(8'd255, 1'b1); push(8'd254, 1'b1); push(8'd255, 1'b1); push(8'd254, 1'b1);
    take(1'b0);

    // Backpressure: result held, input refused
    push(8'd3, 1'b0); push(8'd9, 1'b0); push(8'd1, 1'b0); push(8'd4, 1'b0);
    held      = sb[0].res;
    in_valid  = 1'b1;
    in_data   = 8'd77;
    in_select = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_out_result", 32'(out_result), 32'(held));
    end
    chk("bp_grp_cnt", 32'(grp_cnt), 32'd0);
    in_valid = 1'b0;
    take(1'b0);
    push(8'd5, 1'b1); push(8'd6, 1'b1); push(8'd7, 1'b1); push(8'd8, 1'b1);
    take(1'b0);

    // Reset mid-group discards the partial group
    push(8'd100, 1'b0); push(8'd150, 1'b0);
    chk("mid_grp_cnt", 32'(grp_cnt), 32'd2);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    m_cnt = 0;
    chk("mid_rst_grp_cnt", 32'(grp_cnt), 32'd0);
    chk("mid_rst_out_result", 32'(out_result), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    push(8'd1, 1'b0); push(8'd2, 1'b0); push(8'd3, 1'b0); push(8'd4, 1'b0);
    take(1'b0);

`ifdef MMS_RUNNING_EN
    // Running maximum
    run_clr = 1'b1;
    @(posedge clk); #1;
    run_clr = 1'b0;
    chk("run_clr0", 32'(run_result), 32'd0);
    push(8'd10, 1'b0); push(8'd50, 1'b0); push(8'd20, 1'b0); push(8'd30, 1'b0);
    take(1'b0);
    chk("run_50", 32'(run_result), 32'd50);
    push(8'd80, 1'b0); push(8'd1, 1'b0); push(8'd2, 1'b0); push(8'd3, 1'b0);
    take(1'b0);
    chk("run_80", 32'(run_result), 32'd80);
    push(8'd9, 1'b0); push(8'd8, 1'b0); push(8'd7, 1'b0); push(8'd60, 1'b0);
    take(1'b0);
    chk("run_80_kept", 32'(run_result), 32'd80);
    push(8'd90, 1'b1); push(8'd95, 1'b1); push(8'd99, 1'b1); push(8'd92, 1'b1);
    take(1'b0);
    chk("run_min_ignored", 32'(run_result), 32'd80);
    push(8'd30, 1'b0); push(8'd10, 1'b0); push(8'd20, 1'b0); push(8'd5, 1'b0);
    take(1'b1);
    chk("run_clr_with_xfer", 32'(run_result), 32'd30);
    run_clr = 1'b1;
    @(posedge clk); #1;
    run_clr = 1'b0;
    chk("run_clr", 32'(run_result), 32'd0);
`endif

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
